cache_fill_assembler: RTL and testbench

Gathers narrow memory-response beats into one full cache line and presents it as a single fill to the bank data store. Sits between the bank's memory-response port and the bank's fill path, so the data store receives `fill`, `line_addr`, `way_sel` and whole-line `fill_data` in one cycle. Provides valid/ready backpressure on both sides and a single line buffer.

---
 rtl/cache_fill_assembler.sv | 136 +++++++++++++
 tb/tb_cache_fill_assembler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_assembler.sv
// cache_fill_assembler: collects BEATS memory-response beats into one line and presents it as a single fill.
// Build option CS_FILL_WRAP_EN: critical-word-first placement, beat k lands in slot (mem_rsp_beat_sel + k) mod BEATS.
module cache_fill_assembler #(
   parameter int LINE_SIZE       = 16,
   parameter int BEAT_SIZE       = 4,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int NUM_WAYS        = 1,
   parameter int TAG_WIDTH       = 8,
   localparam int BEATS          = LINE_SIZE / BEAT_SIZE,
   localparam int BEAT_IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_mem_rsp_valid,
   output logic                         o_mem_rsp_ready,
   input  logic [BEAT_SIZE*8-1:0]       i_mem_rsp_data,
   input  logic [LINE_ADDR_WIDTH-1:0]   i_mem_rsp_line_addr,
   input  logic [NUM_WAYS-1:0]          i_mem_rsp_way_sel,
   input  logic [TAG_WIDTH-1:0]         i_mem_rsp_tag,
   input  logic [BEAT_IDX_W-1:0]        i_mem_rsp_beat_sel,
   output logic                         o_fill_valid,
   input  logic                         i_fill_ready,
   output logic [LINE_ADDR_WIDTH-1:0]   o_fill_line_addr,
   output logic [NUM_WAYS-1:0]          o_fill_way_sel,
   output logic [TAG_WIDTH-1:0]         o_fill_tag,
   output logic [LINE_SIZE*8-1:0]       o_fill_data
);

   localparam int BEAT_BITS = BEAT_SIZE * 8;
   localparam logic [0:0] S_COLLECT = 1'b0;
   localparam logic [0:0] S_FULL    = 1'b1;
   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   logic [0:0]                 r_state;
   logic [0:0]                 w_state_next;
   logic [BEAT_IDX_W-1:0]      r_beat_cnt;
   logic [BEAT_IDX_W-1:0]      w_beat_cnt_next;
   logic [BEAT_IDX_W-1:0]      w_slot_raw;
   logic [BEAT_IDX_W-1:0]      w_slot;
   logic [LINE_ADDR_WIDTH-1:0] r_line_addr;
   logic [NUM_WAYS-1:0]        r_way_sel;
   logic [TAG_WIDTH-1:0]       r_tag;
   logic [BEAT_BITS-1:0]       r_line [BEATS];
   logic                       w_accept;
   logic                       w_fire;
   logic                       w_first;
   logic                       w_last;

   // FULL only accepts a new beat when the pending fill leaves in the same cycle.
   assign o_mem_rsp_ready = (r_state == S_COLLECT) | i_fill_ready;
   assign o_fill_valid    = (r_state == S_FULL);
   assign w_accept        = i_mem_rsp_valid & o_mem_rsp_ready;
   assign w_fire          = o_fill_valid & i_fill_ready;
   assign w_first         = (r_beat_cnt == '0);
   assign w_last          = (r_beat_cnt == LAST_BEAT);

`ifdef CS_FILL_WRAP_EN
   logic [BEAT_IDX_W-1:0] r_start;
   logic [BEAT_IDX_W-1:0] w_start;

   assign w_start    = w_first ? i_mem_rsp_beat_sel : r_start;
   assign w_slot_raw = w_start + r_beat_cnt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_start <= '0;
      end else if (w_accept && w_first) begin
         r_start <= i_mem_rsp_beat_sel;
      end
   end
`else
   logic w_unused_beat_sel;

   assign w_unused_beat_sel = ^i_mem_rsp_beat_sel;
   assign w_slot_raw        = r_beat_cnt;
`endif

   // A one-beat line has a single slot; the 1-bit index is forced to it.
   assign w_slot = (BEATS > 1) ? w_slot_raw : '0;

   always_comb begin
      w_state_next    = r_state;
      w_beat_cnt_next = r_beat_cnt;
      if (w_fire) begin
         w_state_next = S_COLLECT;
      end
      if (w_accept) begin
         if (w_last) begin
            w_beat_cnt_next = '0;
            w_state_next    = S_FULL;
         end else begin
            w_beat_cnt_next = r_beat_cnt + BEAT_IDX_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_COLLECT;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_beat_cnt <= w_beat_cnt_next;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_line_addr <= '0;
         r_way_sel   <= '0;
         r_tag       <= '0;
      end else if (w_accept && w_first) begin
         r_line_addr <= i_mem_rsp_line_addr;
         r_way_sel   <= i_mem_rsp_way_sel;
         r_tag       <= i_mem_rsp_tag;
      end
   end

   generate
      for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
         always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
               r_line[gi] <= '0;
            end else if (w_accept && (w_slot == BEAT_IDX_W'(gi))) begin
               r_line[gi] <= i_mem_rsp_data;
            end
         end
         assign o_fill_data[gi*BEAT_BITS +: BEAT_BITS] = r_line[gi];
      end
   endgenerate

   assign o_fill_line_addr = r_line_addr;
   assign o_fill_way_sel   = r_way_sel;
   assign o_fill_tag       = r_tag;

endmodule

// File: tb/tb_cache_fill_assembler.sv
// Self-checking bench for cache_fill_assembler: directed scenarios plus randomized traffic against a line-level model.
module tb_cache_fill_assembler;
   localparam int BEATS = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid;
   logic [31:0]  data;
   logic [25:0]  addr;
   logic [0:0]   way;
   logic [7:0]   tag;
   logic [1:0]   sel;
   logic         fill_ready;
   logic         rsp_ready;
   logic         fill_valid;
   logic [25:0]  f_addr;
   logic [0:0]   f_way;
   logic [7:0]   f_tag;
   logic [127:0] f_data;

   logic         s_valid;
   logic [127:0] s_data;
   logic [25:0]  s_addr;
   logic [0:0]   s_way;
   logic [7:0]   s_tag;
   logic [0:0]   s_sel;
   logic         s_fill_ready;
   logic         s_ready;
   logic         s_fill_valid;
   logic [25:0]  s_f_addr;
   logic [0:0]   s_f_way;
   logic [7:0]   s_f_tag;
   logic [127:0] s_f_data;

   int checks = 0;
   int failures = 0;

   // Line-level reference: a list of collected beats and one pending fill.
   bit          m_full;
   int          m_cnt;
   int          m_start;
   logic [25:0] m_addr;
   logic [0:0]  m_way;
   logic [7:0]  m_tag;
   logic [31:0] m_line [BEATS];

   always #5 clk = ~clk;

   cache_fill_assembler dut (
      .i_clk(clk), .i_reset(rst),
      .i_mem_rsp_valid(valid), .o_mem_rsp_ready(rsp_ready),
      .i_mem_rsp_data(data), .i_mem_rsp_line_addr(addr),
      .i_mem_rsp_way_sel(way), .i_mem_rsp_tag(tag), .i_mem_rsp_beat_sel(sel),
      .o_fill_valid(fill_valid), .i_fill_ready(fill_ready),
      .o_fill_line_addr(f_addr), .o_fill_way_sel(f_way),
      .o_fill_tag(f_tag), .o_fill_data(f_data)
   );

   cache_fill_assembler #(.LINE_SIZE(16), .BEAT_SIZE(16)) dut_single (
      .i_clk(clk), .i_reset(rst),
      .i_mem_rsp_valid(s_valid), .o_mem_rsp_ready(s_ready),
      .i_mem_rsp_data(s_data), .i_mem_rsp_line_addr(s_addr),
      .i_mem_rsp_way_sel(s_way), .i_mem_rsp_tag(s_tag), .i_mem_rsp_beat_sel(s_sel),
      .o_fill_valid(s_fill_valid), .i_fill_ready(s_fill_ready),
      .o_fill_line_addr(s_f_addr), .o_fill_way_sel(s_f_way),
      .o_fill_tag(s_f_tag), .o_fill_data(s_f_data)
   );

   function automatic logic [127:0] m_data();
      logic [127:0] r;
      for (int i = 0; i < BEATS; i++) r[i*32 +: 32] = m_line[i];
      return r;
   endfunction

   task automatic m_reset();
      m_full = 0; m_cnt = 0; m_start = 0; m_addr = '0; m_way = '0; m_tag = '0;
      for (int i = 0; i < BEATS; i++) m_line[i] = '0;
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input logic [25:0] a,
                        input logic [7:0] t, input logic [1:0] s, input bit fr);
      valid = v; data = d; addr = a; way = 1'b1; tag = t; sel = s; fill_ready = fr;
   endtask

   // One clock: the model takes the same inputs the DUT sees at the edge.
   task automatic tick();
      bit acc;
      int slot;
      @(posedge clk);
      acc = valid && (!m_full || fill_ready);
      if (m_full && fill_ready) m_full = 0;
      if (acc) begin
         if (m_cnt == 0) begin
            m_addr = addr; m_way = way; m_tag = tag; m_start = int'(sel);
         end
`ifdef CS_FILL_WRAP_EN
         slot = (m_start + m_cnt) % BEATS;
`else
         slot = m_cnt;
`endif
         m_line[slot] = data;
         m_cnt++;
         if (m_cnt == BEATS) begin
            m_cnt = 0;
            m_full = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] b;
      rst = 1'b1;
      drive(0, '0, '0, '0, '0, 1);
      s_valid = 0; s_data = '0; s_addr = '0; s_way = 1'b1; s_tag = '0; s_sel = '0; s_fill_ready = 1;
      m_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL reset_fill_valid got=%b want=0", fill_valid); end
      checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL reset_rsp_ready got=%b want=1", rsp_ready); end
      checks++; if (f_data !== 128'h0) begin failures++; $display("FAIL reset_fill_data got=%h want=0", f_data); end
      checks++; if ({f_addr, f_way, f_tag} !== '0) begin failures++; $display("FAIL reset_fill_meta got=%h/%b/%h want=0", f_addr, f_way, f_tag); end
      // Load a line, hold it, then reset between edges: outputs must clear without a clock.
      for (int i = 0; i < BEATS; i++) begin
         b = $urandom;
         drive(1, b, 26'h2A5, 8'h3C, 2'd0, 0);
         tick();
      end
      drive(0, '0, '0, '0, '0, 0);
      checks++; if (fill_valid !== 1'b1) begin failures++; $display("FAIL reset_preload_valid got=%b want=1", fill_valid); end
      #2 rst = 1'b1;
      #1;
      m_reset();
      checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL reset_async_valid got=%b want=0", fill_valid); end
      checks++; if (f_data !== 128'h0) begin failures++; $display("FAIL reset_async_data got=%h want=0", f_data); end
      checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL reset_async_ready got=%b want=1", rsp_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_basic_line();
      logic [31:0] beats [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int i = 0; i < BEATS; i++) begin
         drive(1, beats[i], 26'h123, 8'h05, 2'd0, 1);
         tick();
         checks++;
         if (fill_valid !== (i == BEATS - 1)) begin
            failures++; $display("FAIL basic_valid_beat%0d got=%b want=%b", i, fill_valid, i == BEATS - 1);
         end
      end
      checks++; if (f_data !== 128'h44444444_33333333_22222222_11111111) begin failures++; $display("FAIL basic_data got=%h want=44444444333333332222222211111111", f_data); end
      checks++; if (f_addr !== 26'h123) begin failures++; $display("FAIL basic_addr got=%h want=123", f_addr); end
      checks++; if (f_tag !== 8'h05 || f_way !== 1'b1) begin failures++; $display("FAIL basic_tag_way got=%h/%b want=05/1", f_tag, f_way); end
      drive(0, '0, '0, '0, '0, 1);
      tick();
      checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b want=0", fill_valid); end
      $display("test_basic_line done");
   endtask

   task automatic test_stall();
      logic [31:0]  b [4];
      logic [127:0] exp_line;
      for (int i = 0; i < BEATS; i++) begin
         b[i] = $urandom;
         drive(1, b[i], 26'h3FF_0001, 8'hA7, 2'd0, 0);
         tick();
      end
      exp_line = {b[3], b[2], b[1], b[0]};
      for (int c = 0; c < 5; c++) begin
         drive(1, $urandom, 26'h0BAD, 8'hEE, 2'd0, 0);
         #1;
         checks++; if (rsp_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_c%0d got=%b want=0", c, rsp_ready); end
         tick();
         checks++; if (fill_valid !== 1'b1) begin failures++; $display("FAIL stall_valid_c%0d got=%b want=1", c, fill_valid); end
         checks++; if (f_data !== exp_line || f_addr !== 26'h3FF_0001 || f_tag !== 8'hA7) begin
            failures++; $display("FAIL stall_hold_c%0d got=%h/%h/%h want=%h/3ff0001/a7", c, f_data, f_addr, f_tag, exp_line);
         end
      end
      drive(0, '0, '0, '0, '0, 1);
      #1;
      checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL stall_release_ready got=%b want=1", rsp_ready); end
      tick();
      checks++; if (fill_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid got=%b want=0", fill_valid); end
      $display("test_stall done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [4];
      logic [31:0] b [4];
      for (int i = 0; i < BEATS; i++) begin
         a[i] = $urandom; b[i] = $urandom;
      end
      for (int i = 0; i < BEATS; i++) begin
         drive(1, a[i], 26'h00A_0A0A, 8'h1A, 2'd0, 1);
         tick();
      end
      checks++; if (fill_valid !== 1'b1 || f_addr !== 26'h00A_0A0A) begin failures++; $display("FAIL b2b_A_fill got=%b/%h want=1/00a0a0a", fill_valid, f_addr); end
      for (int i = 0; i < BEATS; i++) begin
         drive(1, b[i], 26'h00B_0B0B, 8'h1B, 2'd0, 1);
         #1;
         checks++; if (rsp_ready !== 1'b1) begin failures++; $display("FAIL b2b_B_ready_beat%0d got=%b want=1", i, rsp_ready); end
         tick();
         checks++;
         if (fill_valid !== (i == BEATS - 1)) begin
            failures++; $display("FAIL b2b_B_valid_beat%0d got=%b want=%b", i, fill_valid, i == BEATS - 1);
         end
      end
      checks++; if (f_addr !== 26'h00B_0B0B || f_tag !== 8'h1B) begin failures++; $display("FAIL b2b_B_meta got=%h/%h want=00b0b0b/1b", f_addr, f_tag); end
      checks++; if (f_data !== {b[3], b[2], b[1], b[0]}) begin failures++; $display("FAIL b2b_B_data got=%h want=%h", f_data, {b[3], b[2], b[1], b[0]}); end
      drive(0, '0, '0, '0, '0, 1);
      tick();
      $display("test_back_to_back done");
   endtask

   task automatic test_reset_midline();
      logic [31:0] b [4];
      for (int i = 0; i < 2; i++) begin
         drive(1, $urandom, 26'h0AA, 8'h77, 2'd0, 1);
         tick();
      end
      drive(0, '0, '0, '0, '0, 1);
      #2 rst = 1'b1;
      #1;
      m_reset();
      checks++; if (fill_valid !== 1'b0 || rsp_ready !== 1'b1) begin failures++; $display("FAIL midreset_outputs got=%b/%b want=0/1", fill_valid, rsp_ready); end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         b[i] = $urandom;
         drive(1, b[i], 26'h155, 8'h09, 2'd0, 1);
         tick();
         checks++;
         if (fill_valid !== (i == BEATS - 1)) begin
            failures++; $display("FAIL midreset_valid_beat%0d got=%b want=%b", i, fill_valid, i == BEATS - 1);
         end
      end
      checks++; if (f_addr !== 26'h155 || f_tag !== 8'h09) begin failures++; $display("FAIL midreset_meta got=%h/%h want=155/09", f_addr, f_tag); end
      checks++; if (f_data !== {b[3], b[2], b[1], b[0]}) begin failures++; $display("FAIL midreset_data got=%h want=%h", f_data, {b[3], b[2], b[1], b[0]}); end
      drive(0, '0, '0, '0, '0, 1);
      tick();
      $display("test_reset_midline done");
   endtask

   task automatic test_wrap();
      logic [31:0]  beats [4] = '{32'hAA, 32'hBB, 32'hCC, 32'hDD};
      logic [127:0] exp_line;
`ifdef CS_FILL_WRAP_EN
      exp_line = {32'hBB, 32'hAA, 32'hDD, 32'hCC};
`else
      exp_line = {32'hDD, 32'hCC, 32'hBB, 32'hAA};
`endif
      for (int i = 0; i < BEATS; i++) begin
         // Only the first beat's selector may matter; later beats carry junk.
         drive(1, beats[i], 26'h321, 8'h42, (i == 0) ? 2'd2 : 2'($urandom_range(0, 3)), 1);
         tick();
      end
      checks++; if (f_data !== exp_line) begin failures++; $display("FAIL wrap_data got=%h want=%h", f_data, exp_line); end
      drive(0, '0, '0, '0, '0, 1);
      tick();
      $display("test_wrap done");
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 400; c++) begin
         drive(($urandom_range(0, 9) < 7), $urandom, 26'($urandom), 8'($urandom),
               2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 6));
         #1;
         checks++;
         if (rsp_ready !== (!m_full || fill_ready)) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL rand_ready_c%0d got=%b want=%b", c, rsp_ready, !m_full || fill_ready);
         end
         tick();
         checks++;
         if (fill_valid !== m_full) begin
            failures++; bad++;
            if (bad < 10) $display("FAIL rand_valid_c%0d got=%b want=%b", c, fill_valid, m_full);
         end else if (m_full) begin
            checks++;
            if (f_data !== m_data() || f_addr !== m_addr || f_tag !== m_tag || f_way !== m_way) begin
               failures++; bad++;
               if (bad < 10) $display("FAIL rand_fill_c%0d got=%h/%h/%h want=%h/%h/%h", c, f_data, f_addr, f_tag, m_data(), m_addr, m_tag);
            end
         end
      end
      drive(0, '0, '0, '0, '0, 1);
      tick();
      $display("test_random done");
   endtask

   task automatic test_single_beat();
      logic [127:0] prev_d;
      logic [25:0]  prev_a;
      for (int c = 0; c < 12; c++) begin
         s_valid = 1; s_fill_ready = 1;
         s_data = {$urandom, $urandom, $urandom, $urandom};
         s_addr = 26'($urandom); s_tag = 8'($urandom);
         #1;
         checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL single_ready_c%0d got=%b want=1", c, s_ready); end
         prev_d = s_data; prev_a = s_addr;
         @(posedge clk); #1;
         checks++;
         if (s_fill_valid !== 1'b1 || s_f_data !== prev_d || s_f_addr !== prev_a) begin
            failures++; $display("FAIL single_fill_c%0d got=%b/%h/%h want=1/%h/%h", c, s_fill_valid, s_f_data, s_f_addr, prev_d, prev_a);
         end
      end
      s_fill_ready = 0; s_data = ~prev_d;
      #1;
      checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL single_stall_ready got=%b want=0", s_ready); end
      @(posedge clk); #1;
      checks++; if (s_fill_valid !== 1'b1 || s_f_data !== prev_d) begin failures++; $display("FAIL single_stall_hold got=%b/%h want=1/%h", s_fill_valid, s_f_data, prev_d); end
      s_valid = 0; s_fill_ready = 1;
      @(posedge clk); #1;
      checks++; if (s_fill_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b want=0", s_fill_valid); end
      $display("test_single_beat done");
   endtask

   initial begin
      test_reset();
      test_basic_line();
      test_stall();
      test_back_to_back();
      test_reset_midline();
      test_wrap();
      test_random();
      test_single_beat();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
